// File: rtl/fp8_multiplier_behavioral.sv
// E4M3 (S-EEEE-MMM, bias 7) multiplier with a single output register stage.
// Subnormal inputs flush to zero, the product truncates toward zero, and an
// out-of-range magnitude saturates to MAX_MAG. The ovf/unf/nan status flags
// are registered alongside the product and are mutually exclusive.
module fp8_multiplier_behavioral #(
  parameter int unsigned EXP_BIAS = 7,
  parameter logic [7:0]  MAX_MAG  = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  output logic [7:0] product,
  output logic       ovf,
  output logic       unf,
  output logic       nan
);

  localparam logic signed [6:0] BIAS_S = 7'(EXP_BIAS);

  logic              sign_r;
  logic              a_nan, b_nan, a_zero, b_zero;
  logic [3:0]        sig_a, sig_b;
  logic [7:0]        sig_p;
  logic [2:0]        man_n;
  logic signed [6:0] exp_a, exp_b, exp_sum, exp_n;
  logic [7:0]        nxt_product;
  logic              nxt_ovf, nxt_unf, nxt_nan;

  // Decode both operands, multiply, normalize, then apply range handling.
  always_comb begin
    sign_r  = a[7] ^ b[7];
    a_nan   = (a[6:3] == 4'hF) && (a[2:0] == 3'h7);
    b_nan   = (b[6:3] == 4'hF) && (b[2:0] == 3'h7);
    a_zero  = (a[6:3] == 4'h0);
    b_zero  = (b[6:3] == 4'h0);
    sig_a   = {1'b1, a[2:0]};
    sig_b   = {1'b1, b[2:0]};
    sig_p   = 8'(sig_a) * 8'(sig_b);
    exp_a   = signed'({3'b000, a[6:3]});
    exp_b   = signed'({3'b000, b[6:3]});
    exp_sum = exp_a + exp_b - BIAS_S;
    // The significand product lies in [1,4); a set top bit means one extra binade.
    if (sig_p[7]) begin
      man_n = 3'(sig_p >> 4);
      exp_n = exp_sum + 7'sd1;
    end else begin
      man_n = 3'(sig_p >> 3);
      exp_n = exp_sum;
    end

    nxt_product = '0;
    nxt_ovf     = 1'b0;
    nxt_unf     = 1'b0;
    nxt_nan     = 1'b0;
    if (a_nan || b_nan) begin
      nxt_product = 8'h7F;
      nxt_nan     = 1'b1;
    end else if (a_zero || b_zero) begin
      nxt_product = '0;
    end else if (exp_n <= 7'sd0) begin
      nxt_product = '0;
      nxt_unf     = 1'b1;
    end else if ((exp_n > 7'sd15) || ((exp_n == 7'sd15) && (man_n == 3'b111))) begin
      nxt_product = {sign_r, MAX_MAG[6:0]};
      nxt_ovf     = 1'b1;
    end else begin
      nxt_product = {sign_r, exp_n[3:0], man_n};
    end
  end

  // Capture the result on valid input; otherwise hold the result and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nan       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= nxt_product;
        ovf     <= nxt_ovf;
        unf     <= nxt_unf;
        nan     <= nxt_nan;
      end
    end
  end

endmodule

// File: tb/tb_fp8_multiplier_behavioral.sv
// Bench for fp8_multiplier_behavioral: a real-valued reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_fp8_multiplier_behavioral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       out_valid;
  logic [7:0] product;
  logic       ovf, unf, nan;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: {ovf,unf,nan} flags and product, as the outputs must look.
  logic       m_valid;
  logic [7:0] m_prod;
  logic [2:0] m_flags;

  fp8_multiplier_behavioral #(.EXP_BIAS(7), .MAX_MAG(8'h7E)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a_in),
    .b        (b_in),
    .out_valid(out_valid),
    .product  (product),
    .ovf      (ovf),
    .unf      (unf),
    .nan      (nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_mag(input logic [7:0] x);
    return (1.0 + real'(int'(x[2:0])) / 8.0) * pow2(int'(x[6:3]) - 7);
  endfunction

  // Exact magnitude product, renormalized into [1,2) and truncated to 3 fraction bits.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y);
    real m;
    int  e, be, mant;
    logic s;
    if (x[6:0] == 7'h7F || y[6:0] == 7'h7F) return {3'b001, 8'h7F};
    if (x[6:3] == 4'h0 || y[6:3] == 4'h0)   return {3'b000, 8'h00};
    s = x[7] ^ y[7];
    m = fp_mag(x) * fp_mag(y);
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mant = int'($floor((m - 1.0) * 8.0));
    be   = e + 7;
    if (be <= 0) return {3'b010, 8'h00};
    if (be > 15 || (be == 15 && mant == 7)) return {3'b100, s, 7'h7E};
    return {3'b000, s, 4'(be), 3'(mant)};
  endfunction

  // Reference register: mirrors the observable register/hold/reset behaviour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_prod  <= '0;
      m_flags <= '0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) {m_flags, m_prod} <= model(a_in, b_in);
    end
  end

  // Every cycle, away from the active edge, compare all outputs with the model.
  always @(negedge clk) begin
    chk("cyc_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_result", 32'({ovf, unf, nan, product}), 32'({m_flags, m_prod}));
  end

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid = v;
    a_in     = x;
    b_in     = y;
  endtask

  // Issue one valid pair and check the registered result against a literal.
  task automatic lit(input string name, input logic [7:0] x, input logic [7:0] y,
                     input logic [10:0] exp);
    drive(1'b1, x, y);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, 32'({ovf, unf, nan, product}), 32'(exp));
  endtask

  initial begin
    // Pin the model itself to hand-computed values.
    chk("model_6x3p5",  32'(model(8'h4C, 8'h46)), 32'h05A);
    chk("model_norm",   32'(model(8'h3C, 8'h3C)), 32'h041);
    chk("model_ovf",    32'(model(8'hFE, 8'h40)), 32'h4FE);
    chk("model_unf",    32'(model(8'h08, 8'h08)), 32'h200);

    #7;
    chk("reset_outputs", 32'({out_valid, ovf, unf, nan, product}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    lit("mul_6x3p5",   8'h4C, 8'h46, 11'h05A);
    lit("zero_a",      8'h00, 8'h46, 11'h000);
    lit("zero_neg_b",  8'h00, 8'hC6, 11'h000);
    lit("neg_result",  8'h40, 8'hC6, 11'h0CE);
    lit("neg_x_neg",   8'hC0, 8'hC6, 11'h04E);
    lit("norm_shift",  8'h3C, 8'h3C, 11'h041);
    lit("no_shift",    8'h38, 8'h3C, 11'h03C);
    lit("ovf_pos",     8'h7E, 8'h40, 11'h47E);
    lit("ovf_neg",     8'hFE, 8'h40, 11'h4FE);
    lit("unf",         8'h08, 8'h08, 11'h200);
    lit("nan_a",       8'h7F, 8'h38, 11'h17F);
    lit("nan_b_zero_a", 8'h00, 8'hFF, 11'h17F);
    lit("max_x_one",   8'h7E, 8'h38, 11'h07E);

    // Valid drop: out_valid falls, product and flags hold.
    drive(1'b0, 8'h4C, 8'h46);
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_result", 32'({ovf, unf, nan, product}), 32'h07E);

    // Back-to-back stream, checked each cycle by the model.
    for (int i = 0; i < 60; i++)
      drive((i % 9) != 8, 8'($urandom), 8'($urandom));
    lit("stream_tail", 8'h4C, 8'h46, 11'h05A);

    // Asynchronous reset between edges clears outputs without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({out_valid, ovf, unf, nan, product}), 32'h0);
    drive(1'b1, 8'h7E, 8'h40);
    @(negedge clk);
    chk("reset_held", 32'({out_valid, ovf, unf, nan, product}), 32'h0);
    rst_n = 1'b1;
    lit("after_reset", 8'h38, 8'h3C, 11'h03C);

    drive(1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp8_multiplier_behavioral.md
Name: fp8_multiplier_behavioral

Overview:
- Single-cycle registered multiplier for two 8-bit floating-point operands in E4M3 format: S-EEEE-MMM, exponent bias 7.
- Used as the multiply stage feeding the FP8 MAC accumulator.
- Result and status flags are captured in output registers one clock after a valid input.

Parameters:
- EXP_BIAS, 7, exponent bias of the E4M3 format. Fixed; no other value is supported.
- MAX_MAG, 8'h7E, largest finite magnitude (0_1111_110 = 448.0). Used as the saturation value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  8  operand A, E4M3.
- b  input  8  operand B, E4M3.
- out_valid  output  1  product and flags are valid (registered).
- product  output  8  A*B in E4M3 (registered).
- ovf  output  1  result saturated to MAX_MAG (registered).
- unf  output  1  nonzero exact result flushed to zero (registered).
- nan  output  1  NaN input detected (registered).

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears product, out_valid, ovf, unf and nan to 0, with no clock required.
  - Reset taking effect mid-operation discards any in-flight result.
- Latency:
  - When in_valid=1 at a rising edge, the result of that a/b is presented on the outputs after that edge, with out_valid=1.
  - When in_valid=0 at an edge, out_valid goes to 0 and product/flags hold their last values.
  - Back-to-back valid inputs give one result per cycle. There is no backpressure.
- Field decode:
  - sign = bit7, exp = bits[6:3], man = bits[2:0].
  - exp==0 means zero: subnormals are flushed to zero on input.
  - exp==4'hF with man==3'h7 is NaN.
- Special-case priority:
  1. NaN: if either input is NaN, product = 8'h7F and nan=1.
  2. Zero: otherwise, if either input is zero, product = 8'h00 (always +0, regardless of signs) and all flags are 0.
- Normal path:
  - Sign: s = sa XOR sb.
  - Significands: {1,ma} × {1,mb}, an unsigned 4×4 multiply giving an 8-bit product p.
  - Unbiased exponent: e = ea + eb − 7. Compute it in at least 6 signed bits so no internal overflow or wrap-around occurs.
  - Normalize: if p[7]=1, take mantissa = p[6:4] and e = e+1; otherwise take mantissa = p[5:3].
  - Rounding: truncate (round toward zero). Discarded bits are dropped. Example: 21.0 becomes 20.0.
- Range handling after normalization:
  - Underflow: if e ≤ 0, product = 8'h00 and unf=1.
  - Overflow: if e > 15, or e == 15 with mantissa == 3'b111, product = {s, 7'h7E} and ovf=1.
  - Otherwise: product = {s, e[3:0], mantissa}.
- The ovf, unf and nan flags are mutually exclusive.

Test Plan:
- 8'h4C (6.0) × 8'h46 (3.5) with in_valid → next cycle: out_valid=1, product=8'h5A (20.0, truncated from 21.0), all flags 0.
- 8'h00 × 8'h46 → 8'h00, flags 0. Repeat with b=8'hC6 → still 8'h00.
- 8'h40 × 8'hC6 → 8'hCE (−7.0). Then 8'hC0 × 8'hC6 → 8'h4E (+7.0).
- 8'h3C × 8'h3C → 8'h41 (normalization shift). 8'h38 × 8'h3C → 8'h3C (no shift).
- Range extremes:
  - 8'h7E × 8'h40 → 8'h7E with ovf=1.
  - 8'hFE × 8'h40 → 8'hFE with ovf=1.
  - 8'h08 × 8'h08 → 8'h00 with unf=1.
  - 8'h7F × 8'h38 → 8'h7F with nan=1.
- Control:
  - Streaming valid inputs produce one result per cycle.
  - Dropping in_valid gives out_valid=0 with product held.
  - Asserting rst_n low between clock edges clears all outputs immediately.
